// File: rtl/dpd_lut_pkg.sv
// Shared types and constants for the DPD LUT loader: FSM states, AXI response
// codes and default register/LUT byte addresses.
package dpd_lut_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      IDC_LO = 3'd1,
      IDC_HI = 3'd2,
      LUT_WR = 3'd3,
      LUT_RD = 3'd4,
      FINISH = 3'd5
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [15:0] DEF_IDC_L_ADDR    = 16'h0014;
   localparam logic [15:0] DEF_IDC_H_ADDR    = 16'h0018;
   localparam logic [15:0] DEF_LUT_BASE_ADDR = 16'h8000;

endpackage

// File: rtl/axi_lite_mst_xfer.sv
// Single-beat AXI-Lite master: one read or write per req, ack pulses on the
// completing B or R handshake with the response code alongside.
module axi_lite_mst_xfer
   import dpd_lut_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic [1:0]  resp,
   output logic [31:0] rd_data,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [15:0] m_axi_awaddr,
   output logic [2:0]  m_axi_awprot,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   input  logic [1:0]  m_axi_bresp,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   output logic [15:0] m_axi_araddr,
   output logic [2:0]  m_axi_arprot,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   input  logic [1:0]  m_axi_rresp,
   input  logic [31:0] m_axi_rdata
);

   logic        wr_pend, rd_pend;
   logic [15:0] addr_q;
   logic [31:0] wdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         wr_pend       <= 1'b0;
         rd_pend       <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
      end else if (req && !wr_pend && !rd_pend) begin
         addr_q        <= addr;
         wdata_q       <= wdata;
         wr_pend       <= wr;
         rd_pend       <= !wr;
         m_axi_awvalid <= wr;
         m_axi_wvalid  <= wr;
         m_axi_arvalid <= !wr;
      end else begin
         // AW and W retire independently; B is only accepted once both are gone
         if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
         if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
         if (m_axi_arvalid && m_axi_arready) m_axi_arvalid <= 1'b0;
         if (m_axi_bvalid && m_axi_bready)   wr_pend       <= 1'b0;
         if (m_axi_rvalid && m_axi_rready)   rd_pend       <= 1'b0;
      end
   end

   assign m_axi_awaddr = addr_q;
   assign m_axi_araddr = addr_q;
   assign m_axi_wdata  = wdata_q;
   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign m_axi_wstrb  = 4'hF;
   assign m_axi_bready = wr_pend && !m_axi_awvalid && !m_axi_wvalid;
   assign m_axi_rready = rd_pend && !m_axi_arvalid;

   assign ack     = (m_axi_bvalid && m_axi_bready) || (m_axi_rvalid && m_axi_rready);
   assign resp    = rd_pend ? m_axi_rresp : m_axi_bresp;
   assign rd_data = m_axi_rdata;

endmodule

// File: rtl/axi_dpd_lut_loader.sv
// Loads the lutIdc register pair and then the DPD LUT over AXI-Lite.
// Define AXI_DPD_LUT_LOADER_READBACK_EN to add a read-back checksum pass.
module axi_dpd_lut_loader
   import dpd_lut_pkg::*;
#(
   parameter int          LUT_ADDR_WIDTH = 10,
   parameter logic [15:0] LUT_BASE_ADDR  = DEF_LUT_BASE_ADDR,
   parameter logic [15:0] IDC_L_ADDR     = DEF_IDC_L_ADDR,
   parameter logic [15:0] IDC_H_ADDR     = DEF_IDC_H_ADDR
)(
   input  logic                      m_axi_aclk,
   input  logic                      m_axi_areset,
   input  logic                      start,
   input  logic [63:0]               lut_idc,
   input  logic                      s_entry_valid,
   output logic                      s_entry_ready,
   input  logic [31:0]               s_entry_data,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [15:0]               m_axi_awaddr,
   output logic [2:0]                m_axi_awprot,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   output logic [31:0]               m_axi_wdata,
   output logic [3:0]                m_axi_wstrb,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   input  logic [1:0]                m_axi_bresp,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   output logic [15:0]               m_axi_araddr,
   output logic [2:0]                m_axi_arprot,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   input  logic [1:0]                m_axi_rresp,
   input  logic [31:0]               m_axi_rdata,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [LUT_ADDR_WIDTH:0]   entry_cnt
);

   localparam logic [LUT_ADDR_WIDTH:0] LUT_DEPTH = (LUT_ADDR_WIDTH+1)'(1) << LUT_ADDR_WIDTH;
   localparam logic [LUT_ADDR_WIDTH:0] LAST_CNT  = LUT_DEPTH - 1'b1;

   state_t                  state, nstate;
   logic [63:0]             idc_q;
   logic [LUT_ADDR_WIDTH:0] idx;
   logic [31:0]             cksum;
   logic                    pend;
   logic                    req, wr, ack, resp_bad, accept;
   logic [15:0]             addr, lut_addr;
   logic [31:0]             wdata, rd_data;
   logic [1:0]              resp;
   logic                    x_arvalid, x_rready, x_arready, x_rvalid;
   logic [15:0]             x_araddr;
   logic [2:0]              x_arprot;
   logic [1:0]              x_rresp;
   logic [31:0]             x_rdata;

   assign lut_addr = LUT_BASE_ADDR + (16'(idx) << 2);
   assign accept   = s_entry_valid && s_entry_ready;
   assign resp_bad = ack && (resp != RESP_OKAY);

   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) state <= IDLE;
      else              state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:   if (start) nstate = IDC_LO;
         IDC_LO: if (ack) nstate = resp_bad ? FINISH : IDC_HI;
         IDC_HI: if (ack) nstate = resp_bad ? FINISH : LUT_WR;
         LUT_WR: if (ack) begin
            if (resp_bad) nstate = FINISH;
`ifdef AXI_DPD_LUT_LOADER_READBACK_EN
            else if (entry_cnt == LAST_CNT) nstate = LUT_RD;
`else
            else if (entry_cnt == LAST_CNT) nstate = FINISH;
`endif
         end
`ifdef AXI_DPD_LUT_LOADER_READBACK_EN
         LUT_RD: if (ack && (resp_bad || idx == LUT_DEPTH)) nstate = FINISH;
`endif
         FINISH: nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      busy          = (state != IDLE) && (state != FINISH);
      done          = (state == FINISH);
      s_entry_ready = (state == LUT_WR) && !pend && (idx != LUT_DEPTH);
      req           = 1'b0;
      wr            = 1'b1;
      addr          = IDC_L_ADDR;
      wdata         = idc_q[31:0];
      case (state)
         IDC_LO: req = !pend;
         IDC_HI: begin
            req   = !pend;
            addr  = IDC_H_ADDR;
            wdata = idc_q[63:32];
         end
         LUT_WR: begin
            req   = accept;
            addr  = lut_addr;
            wdata = s_entry_data;
         end
`ifdef AXI_DPD_LUT_LOADER_READBACK_EN
         LUT_RD: begin
            req  = !pend && (idx != LUT_DEPTH);
            wr   = 1'b0;
            addr = lut_addr;
         end
`endif
         default: ;
      endcase
   end

`ifdef AXI_DPD_LUT_LOADER_READBACK_EN
   logic [31:0] rd_sum;
`endif

   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         idc_q     <= '0;
         idx       <= '0;
         cksum     <= '0;
         pend      <= 1'b0;
         error     <= 1'b0;
         entry_cnt <= '0;
`ifdef AXI_DPD_LUT_LOADER_READBACK_EN
         rd_sum    <= '0;
`endif
      end else begin
         if (req)      pend <= 1'b1;
         else if (ack) pend <= 1'b0;
         if (state == IDLE && start) begin
            idc_q     <= lut_idc;
            idx       <= '0;
            cksum     <= '0;
            error     <= 1'b0;
            entry_cnt <= '0;
`ifdef AXI_DPD_LUT_LOADER_READBACK_EN
            rd_sum    <= '0;
`endif
         end
         if (accept) begin
            idx   <= idx + 1'b1;
            cksum <= cksum ^ s_entry_data;
         end
         // idx is reused as the read index once the last write is acknowledged
         if (state == LUT_WR && ack) begin
            entry_cnt <= entry_cnt + 1'b1;
            if (!resp_bad && entry_cnt == LAST_CNT) idx <= '0;
         end
         if (resp_bad) error <= 1'b1;
`ifdef AXI_DPD_LUT_LOADER_READBACK_EN
         if (state == LUT_RD) begin
            if (req) idx <= idx + 1'b1;
            if (ack) begin
               rd_sum <= rd_sum ^ rd_data;
               if (!resp_bad && idx == LUT_DEPTH && (rd_sum ^ rd_data) != cksum)
                  error <= 1'b1;
            end
         end
`endif
      end
   end

   axi_lite_mst_xfer u_xfer (
      .clk           (m_axi_aclk),
      .rst           (m_axi_areset),
      .req           (req),
      .wr            (wr),
      .addr          (addr),
      .wdata         (wdata),
      .ack           (ack),
      .resp          (resp),
      .rd_data       (rd_data),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awprot  (m_axi_awprot),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_arvalid (x_arvalid),
      .m_axi_arready (x_arready),
      .m_axi_araddr  (x_araddr),
      .m_axi_arprot  (x_arprot),
      .m_axi_rvalid  (x_rvalid),
      .m_axi_rready  (x_rready),
      .m_axi_rresp   (x_rresp),
      .m_axi_rdata   (x_rdata)
   );

`ifdef AXI_DPD_LUT_LOADER_READBACK_EN
   assign m_axi_arvalid = x_arvalid;
   assign m_axi_araddr  = x_araddr;
   assign m_axi_arprot  = x_arprot;
   assign m_axi_rready  = x_rready;
   assign x_arready     = m_axi_arready;
   assign x_rvalid      = m_axi_rvalid;
   assign x_rresp       = m_axi_rresp;
   assign x_rdata       = m_axi_rdata;
`else
   // read channel is dead in this build; the checksum has no consumer
   logic unused_rd;
   assign m_axi_arvalid = 1'b0;
   assign m_axi_araddr  = '0;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_rready  = 1'b0;
   assign x_arready     = 1'b0;
   assign x_rvalid      = 1'b0;
   assign x_rresp       = RESP_OKAY;
   assign x_rdata       = '0;
   assign unused_rd     = ^{x_arvalid, x_araddr, x_arprot, x_rready, rd_data, cksum,
                            m_axi_arready, m_axi_rvalid, m_axi_rresp, m_axi_rdata};
`endif

endmodule

// File: tb/tb_axi_dpd_lut_loader.sv
// Bench for axi_dpd_lut_loader: AXI-Lite slave memory model, entry source and
// write/read scoreboards, driven from a scenario table plus reset sequence.
module tb_axi_dpd_lut_loader;

   localparam int AW = 3;
   localparam int N  = 8;
`ifdef AXI_DPD_LUT_LOADER_READBACK_EN
   localparam int NRD = N;
`else
   localparam int NRD = 0;
`endif

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [63:0] lut_idc = '0;
   logic        s_entry_valid = 1'b0, s_entry_ready;
   logic [31:0] s_entry_data = '0;
   logic        m_axi_awvalid, m_axi_awready = 1'b0;
   logic [15:0] m_axi_awaddr;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_wvalid, m_axi_wready = 1'b0;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_bvalid = 1'b0, m_axi_bready;
   logic [1:0]  m_axi_bresp = 2'b00;
   logic        m_axi_arvalid, m_axi_arready = 1'b0;
   logic [15:0] m_axi_araddr;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_rvalid = 1'b0, m_axi_rready;
   logic [1:0]  m_axi_rresp = 2'b00;
   logic [31:0] m_axi_rdata = '0;
   logic        busy, done, error;
   logic [AW:0] entry_cnt;

   always #5 clk = ~clk;

   axi_dpd_lut_loader #(.LUT_ADDR_WIDTH(AW)) dut (
      .m_axi_aclk(clk), .m_axi_areset(rst), .start(start), .lut_idc(lut_idc),
      .s_entry_valid(s_entry_valid), .s_entry_ready(s_entry_ready), .s_entry_data(s_entry_data),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
      .m_axi_awprot(m_axi_awprot), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rresp(m_axi_rresp),
      .m_axi_rdata(m_axi_rdata), .busy(busy), .done(done), .error(error), .entry_cnt(entry_cnt)
   );

   typedef struct {
      int   aw_dly;
      int   err_idx;
      int   bad_idx;
      bit   dbl;
      logic exp_err;
      int   exp_cnt;
      int   exp_wr;
   } vec_t;

   typedef struct packed {
      logic [15:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t         exp_wr_q[$];
   logic [15:0] exp_rd_q[$];
   logic [31:0] src_q[$];
   logic [31:0] mem [logic [15:0]];

   int n_vec = 0, n_bad = 0;
   int nwr, nrd, consumed, done_cnt, viol, os;
   int aw_dly = 0;
   logic [15:0] err_a = 16'hFFFF, bad_a = 16'hFFFF;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // pre-edge handshake samples, consumed by the negedge models
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, e_hs, paw, pw, par;
   logic [15:0] aw_a, ar_a;
   logic [31:0] w_d;

   always @(posedge clk) begin
      aw_hs = m_axi_awvalid && m_axi_awready;  aw_a = m_axi_awaddr;
      w_hs  = m_axi_wvalid && m_axi_wready;    w_d  = m_axi_wdata;
      b_hs  = m_axi_bvalid && m_axi_bready;
      ar_hs = m_axi_arvalid && m_axi_arready;  ar_a = m_axi_araddr;
      r_hs  = m_axi_rvalid && m_axi_rready;
      e_hs  = s_entry_valid && s_entry_ready;
      if (rst) begin
         os = 0; paw = 1'b0; pw = 1'b0; par = 1'b0;
      end else begin
         if (m_axi_awvalid && !paw) os++;
         if (m_axi_arvalid && !par) os++;
         if ((m_axi_awvalid && !paw) != (m_axi_wvalid && !pw)) viol++;
         if (os > 1) viol++;
         if (m_axi_bready && os == 0) viol++;
         if (m_axi_rready && os == 0) viol++;
         if (m_axi_awvalid && m_axi_awprot != 3'b000) viol++;
         if (m_axi_arvalid && m_axi_arprot != 3'b000) viol++;
         if (m_axi_wvalid && m_axi_wstrb != 4'hF) viol++;
         if (s_entry_ready && error) viol++;
         if (done) done_cnt++;
         if (b_hs) os--;
         if (r_hs) os--;
         paw = m_axi_awvalid; pw = m_axi_wvalid; par = m_axi_arvalid;
      end
   end

   logic        agot = 1'b0, wgot = 1'b0;
   logic [15:0] sa;
   logic [31:0] sd;
   int          wcnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
         m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
         agot = 1'b0; wgot = 1'b0; wcnt = 0;
      end else begin
         if (b_hs) m_axi_bvalid = 1'b0;
         if (r_hs) m_axi_rvalid = 1'b0;
         if (aw_hs) begin agot = 1'b1; sa = aw_a; end
         if (w_hs)  begin wgot = 1'b1; sd = w_d; wcnt = 0; end
         if (agot && wgot && !m_axi_bvalid) begin
            nwr++;
            if (exp_wr_q.size() > 0) begin
               wr_t e;
               e = exp_wr_q.pop_front();
               chk("wr_addr", 64'(sa), 64'(e.a));
               chk("wr_data", 64'(sd), 64'(e.d));
            end
            mem[sa] = sd;
            m_axi_bresp  = (sa == err_a) ? 2'b10 : 2'b00;
            m_axi_bvalid = 1'b1;
            agot = 1'b0; wgot = 1'b0;
         end
         m_axi_awready = m_axi_awvalid && !agot && (aw_dly == 0 || (wgot && wcnt >= aw_dly));
         if (wgot) wcnt++;
         m_axi_wready = m_axi_wvalid && !wgot;
         if (ar_hs) begin
            nrd++;
            if (exp_rd_q.size() > 0) chk("rd_addr", 64'(ar_a), 64'(exp_rd_q.pop_front()));
            m_axi_rdata  = mem.exists(ar_a) ? (mem[ar_a] ^ ((ar_a == bad_a) ? 32'h100 : 32'h0)) : 32'h0;
            m_axi_rresp  = 2'b00;
            m_axi_rvalid = 1'b1;
         end
         m_axi_arready = m_axi_arvalid && !m_axi_rvalid;
      end
   end

   always @(negedge clk) begin
      if (e_hs && src_q.size() > 0) begin
         void'(src_q.pop_front());
         consumed++;
      end
      s_entry_valid = !rst && src_q.size() > 0;
      s_entry_data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
   end

   task automatic setup(input int k, input vec_t v, input logic [63:0] idc);
      int last;
      wr_t e;
      aw_dly = v.aw_dly;
      err_a  = (v.err_idx >= 0) ? 16'h8000 + 16'(4 * v.err_idx) : 16'hFFFF;
      bad_a  = (v.bad_idx >= 0) ? 16'h8000 + 16'(4 * v.bad_idx) : 16'hFFFF;
      exp_wr_q.delete(); exp_rd_q.delete(); src_q.delete();
      nwr = 0; nrd = 0; consumed = 0; done_cnt = 0; viol = 0;
      last = (v.err_idx >= 0) ? v.err_idx : N - 1;
      e.a = 16'h0014; e.d = idc[31:0];  exp_wr_q.push_back(e);
      e.a = 16'h0018; e.d = idc[63:32]; exp_wr_q.push_back(e);
      for (int i = 0; i <= last; i++) begin
         e.a = 16'h8000 + 16'(4 * i); e.d = 32'(i + 1 + k * 256);
         exp_wr_q.push_back(e);
      end
      if (v.err_idx < 0)
         for (int i = 0; i < NRD; i++) exp_rd_q.push_back(16'h8000 + 16'(4 * i));
      for (int i = 0; i < N; i++) src_q.push_back(32'(i + 1 + k * 256));
      @(negedge clk); start = 1'b1; lut_idc = idc;
      @(negedge clk); start = 1'b0; lut_idc = ~idc;
   endtask

   task automatic run(input int k, input vec_t v, input logic [63:0] idc);
      int cyc;
      setup(k, v, idc);
      chk("busy_after_start", 64'(busy), 64'd1);
      if (v.dbl) begin
         repeat (6) @(negedge clk);
         start = 1'b1; lut_idc = 64'h1234_5678_9ABC_DEF0;
         @(negedge clk); start = 1'b0;
      end
      cyc = 0;
      while (done_cnt == 0 && cyc < 2000) begin @(negedge clk); cyc++; end
      chk("done_timeout", 64'(cyc < 2000), 64'd1);
      repeat (10) @(negedge clk);
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("error", 64'(error), 64'(v.exp_err));
      chk("entry_cnt", 64'(entry_cnt), 64'(v.exp_cnt));
      chk("busy_end", 64'(busy), 64'd0);
      chk("ready_end", 64'(s_entry_ready), 64'd0);
      chk("n_writes", 64'(nwr), 64'(v.exp_wr));
      chk("n_reads", 64'(nrd), 64'((v.err_idx < 0) ? NRD : 0));
      chk("consumed", 64'(consumed), 64'((v.err_idx >= 0) ? v.err_idx + 1 : N));
      chk("protocol", 64'(viol), 64'd0);
      chk("wr_left", 64'(exp_wr_q.size()), 64'd0);
   endtask

   vec_t vecs[4];

   initial begin
      int cyc;
      vecs[0] = '{0, -1, -1, 1'b0, 1'b0, 8, 10};
      vecs[1] = '{3, -1, -1, 1'b0, 1'b0, 8, 10};
      vecs[2] = '{0,  2, -1, 1'b0, 1'b1, 3, 5};
      vecs[3] = '{1, -1, -1, 1'b1, 1'b0, 8, 10};

      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_cnt", 64'(entry_cnt), 64'd0);
      chk("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                             m_axi_rready, s_entry_ready}), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      run(0, vecs[0], 64'h0000_00AB_0000_00CD);
      for (int k = 1; k < 4; k++) run(k, vecs[k], {$urandom, $urandom});
`ifdef AXI_DPD_LUT_LOADER_READBACK_EN
      begin
         vec_t rv;
         rv = '{0, -1, 4, 1'b0, 1'b1, 8, 10};
         run(4, rv, {$urandom, $urandom});
      end
`endif

      // reset while the entry-2 write address is still waiting for awready
      setup(5, '{6, -1, -1, 1'b0, 1'b0, 8, 10}, 64'h0000_0011_0000_0022);
      cyc = 0;
      while (!(m_axi_awvalid && m_axi_awaddr == 16'h8004) && cyc < 500) begin
         @(negedge clk); cyc++;
      end
      chk("entry2_aw_seen", 64'(cyc < 500), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                                 m_axi_rready, s_entry_ready}), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      exp_wr_q.delete();
      @(negedge clk);
      run(6, vecs[0], 64'h0000_0033_0000_0044);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
